// File: rtl/btc_pkg.sv
// Shared constants, FSM state type and byte-order helpers for the header feeder.
package btc_pkg;

  localparam int HDR_WORDS = 20;
  localparam int NONCE_IDX = 19;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK
  } state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Bitcoin compares digests as little-endian integers.
  function automatic logic [255:0] bswap256(input logic [255:0] h);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = h[(31-i)*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/hdr_word_server.sv
// Header register file plus the rq/addr -> data/rdy word server.
// The last word is always the byte-swapped live nonce, never the RAM copy.
module hdr_word_server
  import btc_pkg::*;
#(
  parameter int NWORDS = HDR_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] nonce,
  input  logic        rq,
  input  logic [4:0]  addr,
  output logic [31:0] data,
  output logic        rdy
);

  localparam logic [4:0] LAST = 5'(NWORDS - 1);

  logic [31:0] ram [NWORDS];
  logic        rq_q;
  logic [31:0] word;

  // No reset on the RAM: the header survives a sweep reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_addr <= LAST) ram[wr_addr] <= wr_data;
  end

  always_comb begin
    word = '0;
    if (addr == LAST)     word = bswap32(nonce);
    else if (addr < LAST) word = ram[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_q <= 1'b0;
      rdy  <= 1'b0;
      data <= '0;
    end else begin
      rq_q <= rq;
      rdy  <= rq && !rq_q;
      if (rq && !rq_q) data <= word;
    end
  end

endmodule

// File: rtl/header_feeder.sv
// Nonce sweep controller: starts the hasher once per nonce, checks each
// returned hash against the target and reports the first winner or exhaustion.
module header_feeder
  import btc_pkg::*;
#(
  parameter int NWORDS = HDR_WORDS,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [255:0]     target,
  input  logic [31:0]      nonce_start,
  input  logic [31:0]      nonce_end,
  input  logic             go,
  input  logic             abort,
  output logic             hstart,
  input  logic             rq,
  input  logic [4:0]       addr,
  output logic [31:0]      data,
  output logic             rdy,
  input  logic             hdone,
  input  logic [255:0]     hash,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [31:0]      golden_nonce,
  output logic [CNT_W-1:0] hash_count
);

  state_t       state, state_nx;
  logic [31:0]  nonce;
  logic [255:0] hash_q;
  logic         abort_pend;
  logic         win;

  assign win    = bswap256(hash_q) <= target;
  assign hstart = (state == S_START);
  assign busy   = (state != S_IDLE);

  hdr_word_server #(.NWORDS(NWORDS)) u_srv (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .nonce   (nonce),
    .rq      (rq),
    .addr    (addr),
    .data    (data),
    .rdy     (rdy)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go) state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT:  if (hdone) state_nx = S_CHECK;
      S_CHECK: begin
        if (abort_pend || win || nonce == nonce_end) state_nx = S_IDLE;
        else                                         state_nx = S_START;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nonce        <= '0;
      hash_q       <= '0;
      hash_count   <= '0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      golden_nonce <= '0;
      abort_pend   <= 1'b0;
    end else begin
      // The hasher cannot be cancelled, so abort only stops the next start.
      if (state != S_IDLE && abort) abort_pend <= 1'b1;
      case (state)
        S_IDLE: if (go) begin
          nonce      <= nonce_start;
          found      <= 1'b0;
          exhausted  <= 1'b0;
          hash_count <= '0;
          abort_pend <= 1'b0;
        end
        S_WAIT: if (hdone) begin
          hash_q     <= hash;
          hash_count <= hash_count + CNT_W'(1);
        end
        S_CHECK: if (!abort_pend) begin
          if (win) begin
            found        <= 1'b1;
            golden_nonce <= nonce;
          end else if (nonce == nonce_end) begin
            exhausted <= 1'b1;
          end else begin
            nonce <= nonce + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_header_feeder.sv
// Directed bench for header_feeder: genesis header, range sweeps, handshake, abort, reset.
module tb_header_feeder;

  logic         clk = 1'b0;
  logic         rst, wr_en, go, abort, rq, hdone;
  logic [4:0]   wr_addr, addr;
  logic [31:0]  wr_data, nonce_start, nonce_end;
  logic [255:0] target, hash;
  logic         hstart, rdy, busy, found, exhausted;
  logic [31:0]  data, golden_nonce;
  logic [31:0]  hash_count;

  int nvec = 0;
  int nmis = 0;
  int hs_cnt = 0;
  int hs_base;

  localparam logic [255:0] GEN_HASH =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] GEN_TGT = {32'h0, 32'hFFFF0000, 192'h0};
  localparam logic [255:0] ONES = {256{1'b1}};

  logic [31:0] gen [20] = '{
    32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
    32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};

  header_feeder #(.NWORDS(20), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .target(target), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .go(go), .abort(abort), .hstart(hstart), .rq(rq), .addr(addr),
    .data(data), .rdy(rdy), .hdone(hdone), .hash(hash), .busy(busy),
    .found(found), .exhausted(exhausted), .golden_nonce(golden_nonce),
    .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (hstart) hs_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [4:0] a, input logic [31:0] exp);
    rq = 1'b1; addr = a;
    tick();
    chk("rdy_hi", rdy, 1'b1);
    chk("data", data, exp);
    tick();
    chk("rdy_lo", rdy, 1'b0);
    rq = 1'b0;
    tick();
  endtask

  task automatic one_hash(input logic [31:0] exp_w19, input logic [255:0] h);
    int t = 0;
    while (!hstart && t < 20) begin tick(); t++; end
    chk("hstart_seen", hstart, 1'b1);
    tick();
    chk("hstart_1cyc", hstart, 1'b0);
    serve(5'd19, exp_w19);
    hdone = 1'b1; hash = h;
    tick();
    hdone = 1'b0; hash = '0;
  endtask

  task automatic start_sweep(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tg);
    nonce_start = s; nonce_end = e; target = tg;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; go = 0; abort = 0; rq = 0; hdone = 0;
    wr_addr = 0; addr = 0; wr_data = 0; nonce_start = 0; nonce_end = 0;
    target = 0; hash = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_hstart", hstart, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_found", found, 0);
    chk("rst_exh", exhausted, 0);
    chk("rst_data", data, 0);
    chk("rst_golden", golden_nonce, 0);
    chk("rst_count", hash_count, 0);

    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = gen[i];
      tick();
    end
    wr_en = 1'b0;

    // Handshake in idle
    serve(5'd0, 32'h01000000);
    serve(5'd18, 32'hffff001d);
    serve(5'd25, 32'h0);

    // Genesis header
    start_sweep(32'h7C2BAC1D, 32'h7C2BAC1D, GEN_TGT);
    chk("go_busy", busy, 1);
    one_hash(32'h1DAC2B7C, GEN_HASH);
    chk("check_busy", busy, 1);
    tick();
    chk("gen_found", found, 1);
    chk("gen_exh", exhausted, 0);
    chk("gen_golden", golden_nonce, 32'h7C2BAC1D);
    chk("gen_count", hash_count, 1);
    chk("gen_busy", busy, 0);

    // Range exhaustion
    hs_base = hs_cnt;
    start_sweep(32'd5, 32'd7, '0);
    one_hash(32'h05000000, ONES);
    one_hash(32'h06000000, ONES);
    one_hash(32'h07000000, ONES);
    tick();
    chk("exh_exh", exhausted, 1);
    chk("exh_found", found, 0);
    chk("exh_count", hash_count, 3);
    chk("exh_busy", busy, 0);
    repeat (5) tick();
    chk("exh_hstarts", hs_cnt - hs_base, 3);

    // Wrap-around
    start_sweep(32'hFFFFFFFF, 32'h1, '0);
    one_hash(32'hFFFFFFFF, ONES);
    one_hash(32'h00000000, ONES);
    one_hash(32'h01000000, ONES);
    tick();
    chk("wrap_exh", exhausted, 1);
    chk("wrap_count", hash_count, 3);

    // Abort in WAIT
    start_sweep(32'd100, 32'd200, '0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    serve(5'd19, 32'h64000000);
    hs_base = hs_cnt;
    hdone = 1'b1; hash = ONES;
    tick();
    hdone = 1'b0;
    chk("abort_chk_busy", busy, 1);
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_found", found, 0);
    chk("abort_exh", exhausted, 0);
    chk("abort_count", hash_count, 1);
    repeat (5) tick();
    chk("abort_hstarts", hs_cnt - hs_base, 0);

    // go and abort together in idle: go wins, abort discarded
    abort = 1'b1;
    start_sweep(32'd300, 32'd300, '0);
    abort = 1'b0;
    one_hash(32'h2C010000, ONES);
    tick();
    chk("goabort_exh", exhausted, 1);

    // Sweep that wins so golden_nonce is non-zero before reset
    start_sweep(32'd9, 32'd20, ONES);
    one_hash(32'h09000000, 256'h1234);
    tick();
    chk("win_golden", golden_nonce, 32'd9);

    // Reset mid-sweep
    start_sweep(32'd0, 32'd10, '0);
    tick();
    chk("mid_busy", busy, 1);
    do_reset();
    chk("mrst_busy", busy, 0);
    chk("mrst_hstart", hstart, 0);
    chk("mrst_rdy", rdy, 0);
    chk("mrst_data", data, 0);
    chk("mrst_found", found, 0);
    chk("mrst_exh", exhausted, 0);
    chk("mrst_golden", golden_nonce, 0);
    chk("mrst_count", hash_count, 0);
    serve(5'd9, 32'h3ba3edfd);
    serve(5'd17, 32'h29ab5f49);

    // Write while busy is dropped
    start_sweep(32'd0, 32'd10, '0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    do_reset();
    serve(5'd0, 32'h01000000);

    // Write while idle takes effect
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hCAFEF00D;
    tick();
    wr_en = 1'b0;
    serve(5'd1, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/header_feeder.md
# header_feeder

Upstream source for `sha256d_wrapper`. It holds one 80-byte block header (20 × 32-bit words) and serves header words to the hasher over its `rq`/`addr`/`rdy`/`data` word-request handshake. It replaces word 19 with a live nonce and sweeps the nonce range, starting the hasher once per nonce. Each returned hash is compared against a 256-bit target, and the block reports the first winning nonce or exhaustion of the range.

## Interface
Parameters:
- `NWORDS`, 20: header words served; word `NWORDS-1` is the nonce word.
- `CNT_W`, 32: width of `hash_count`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: header word write strobe; honoured only when `busy`=0.
- `wr_addr` in 5: header word index 0..19; indices ≥20 are ignored.
- `wr_data` in 32: header word, big-endian byte order as transmitted.
- `target` in 256: difficulty target, unsigned.
- `nonce_start` in 32: first nonce, numeric value.
- `nonce_end` in 32: last nonce, inclusive.
- `go` in 1: start-sweep pulse; ignored while `busy`=1.
- `abort` in 1: stop-sweep request.
- `hstart` out 1: start pulse to hasher.
- `rq` in 1: word request level from hasher.
- `addr` in 5: requested word index from hasher.
- `data` out 32: served word.
- `rdy` out 1: data-valid pulse to hasher.
- `hdone` in 1: hasher completion.
- `hash` in 256: hasher result, valid while `hdone`=1.
- `busy` out 1: sweep in progress.
- `found` out 1: sticky winning-nonce flag.
- `exhausted` out 1: sticky range-exhausted flag.
- `golden_nonce` out 32: winning nonce.
- `hash_count` out `CNT_W`: hashes completed in the current sweep.

## Operation
- **Header RAM:** 20×32 register file. Written via `wr_*` when idle. Not cleared by `rst`.
- **Nonce word:** served word 19 = byte-swap of the `nonce` register (header stores the nonce little-endian). The RAM value at word 19 is never served.
- **FSM states:**
  - IDLE: `go` → loads `nonce`←`nonce_start`; clears `found`, `exhausted`, `hash_count`, `abort_pend`; goes to START.
  - START: `hstart`=1 for exactly one cycle → WAIT.
  - WAIT: serves requests. `hdone`=1 → CHECK, capturing `hash` into `hash_q` and incrementing `hash_count`.
  - CHECK:
    - If `abort_pend`: → IDLE.
    - Else if byteswap256(`hash_q`) ≤ `target`: `found`←1, `golden_nonce`←`nonce`, → IDLE.
    - Else if `nonce`==`nonce_end`: `exhausted`←1, → IDLE.
    - Otherwise: `nonce`←`nonce`+1 (mod 2^32), → START.
- **Byte order in compare:** byteswap256 reverses all 32 bytes, because Bitcoin compares the hash as a little-endian integer.
- **Abort:** `abort` in any non-IDLE state sets `abort_pend`. The in-flight hash always completes, because the hasher has no cancel. `abort` in IDLE has no effect.
- **Request serving:** rising-edge detect on `rq` (`rq`=1, `rq_q`=0) latches `addr`.
  - The next cycle drives `data` and `rdy`=1 for exactly one cycle.
  - `addr`≥20 serves 0x00000000, and `rdy` still pulses.
  - Serving is independent of FSM state.
- **Wrap-around:** if `nonce_start` > `nonce_end`, the sweep wraps through 0xFFFFFFFF→0 until it reaches `nonce_end`.
- **Status:** `busy` = state≠IDLE. `found` and `exhausted` are never both 1.

## Timing
- **Reset values:** `hstart`, `rdy`, `busy`, `found`, `exhausted` = 0; `data`, `golden_nonce`, `hash_count` = 0; state IDLE; `rq_q`=0.
- **`go` to `hstart`:** `go` sampled at cycle N; `hstart`=1 at N+1; `busy`=1 from N+1.
- **`rq` to `rdy`:** 1 cycle (edge at N; `data`/`rdy` valid at N+1).
- **`hdone` to next `hstart`:** `hdone` at N; CHECK at N+1; next `hstart` at N+2.
- **Status outputs:** `found`/`exhausted`/`busy`=0 all update at CHECK+1.
- **Same-cycle `go` and `abort` in IDLE:** `go` wins; the new sweep starts with `abort_pend`=0.
- **`wr_en` while busy:** dropped silently.
- **`rst` mid-sweep:** immediate return to IDLE with reset values. Header RAM is kept.

## Structure
- **Package `btc_pkg`:**
  - `HDR_WORDS`=20 and `NONCE_IDX`=19.
  - FSM state enum.
  - Function `bswap32`.
  - Function `bswap256`.
- **Sub-module `hdr_word_server`:** one instance. It contains the RAM, the `rq` edge detect, and the `data`/`rdy` register. It takes `nonce` as input.
- **FSM, compare and counters:** remain in `header_feeder`.

## Test plan
- **Genesis header, trivial target:**
  - Stimulus: load the 20 genesis words (word 19 = 0x1DAC2B7C); `nonce_start`=`nonce_end`=0x7C2BAC1D; `target`=0x00000000FFFF0000…0; hasher model returns the genesis hash.
  - Required response: served word 19 = 0x1DAC2B7C; `found`=1; `golden_nonce`=0x7C2BAC1D; `hash_count`=1.
- **Range exhaustion:**
  - Stimulus: `nonce_start`=5, `nonce_end`=7; target=0; hash model always non-zero.
  - Required response: exactly 3 `hstart` pulses; served word 19 = 0x05000000, 0x06000000, 0x07000000; `exhausted`=1; `found`=0; `hash_count`=3.
- **Wrap-around:**
  - Stimulus: `nonce_start`=0xFFFFFFFF, `nonce_end`=0x00000001; never matching.
  - Required response: nonces FFFFFFFF, 0, 1 tried; `hash_count`=3.
- **Request handshake:**
  - Stimulus: `rq` edges with `addr`=0, 18, 25.
  - Required response: `rdy` one cycle after each edge, one cycle wide; `data`=RAM[0], RAM[18], 0x00000000.
- **Abort:**
  - Stimulus: `abort` in WAIT.
  - Required response: no further `hstart` after the pending `hdone`; `busy`=0 two cycles after `hdone`; `found`=`exhausted`=0.
- **Reset mid-sweep and blocked writes:**
  - Stimulus: `rst` during WAIT; then `wr_en` while busy.
  - Required response: after reset, all outputs at reset values and the header is intact; the write while busy leaves the RAM unchanged.
